serial_adder: RTL and testbench

- Parametrised, multi-cycle successor to the team's single-bit gate-level full adder.
- Adds or subtracts two WIDTH-bit operands DIGIT_W bits per clock, rippling the carry through a registered carry flop.
- Valid/ready handshake on both sides.
- Used where area matters more than latency: wide datapaths, accumulators and checksum units.

---
 rtl/serial_adder_pkg.sv | 19 +
 rtl/digit_adder.sv | 26 ++
 rtl/serial_adder.sv | 132 +++++++++++++
 tb/tb_serial_adder.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the digit-serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int calc_ndig(input int width, input int digit_w);
        return width / digit_w;
    endfunction

    // A one-digit configuration still needs a one-bit counter.
    function automatic int calc_cnt_w(input int ndig);
        return (ndig > 1) ? $clog2(ndig) : 1;
    endfunction

endpackage

// File: rtl/digit_adder.sv
// DIGIT_W-bit combinational ripple adder built from full-adder cells.
// msb_cin is the carry into the top bit, used for signed overflow detection.
module digit_adder #(
    parameter int DIGIT_W = 4
) (
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               cin,
    output logic [DIGIT_W-1:0] s,
    output logic               cout,
    output logic               msb_cin
);

    logic [DIGIT_W:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < DIGIT_W; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout    = c[DIGIT_W];
    assign msb_cin = c[DIGIT_W-1];

endmodule

// File: rtl/serial_adder.sv
// Digit-serial add/subtract unit: DIGIT_W bits per clock with a registered carry.
// Optional macro SERIAL_ADDER_ACC_EN adds acc_sel to reuse the last sum as operand A.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int DIGIT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
`ifdef SERIAL_ADDER_ACC_EN
    input  logic             acc_sel,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NDIG  = calc_ndig(WIDTH, DIGIT_W);
    localparam int CNT_W = calc_cnt_w(NDIG);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NDIG - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0]   a_src;
    logic [DIGIT_W-1:0] dig_sum;
    logic               dig_cout;
    logic               dig_msb_cin;

`ifdef SERIAL_ADDER_ACC_EN
    // Outside RUN, sum_q always holds the most recently completed result.
    assign a_src = acc_sel ? sum_q : a;
`else
    assign a_src = a;
`endif

    // Operand registers shift right, so the active digit is always the low one.
    digit_adder #(
        .DIGIT_W(DIGIT_W)
    ) u_digit_adder (
        .a      (a_q[DIGIT_W-1:0]),
        .b      (b_q[DIGIT_W-1:0]),
        .cin    (carry_q),
        .s      (dig_sum),
        .cout   (dig_cout),
        .msb_cin(dig_msb_cin)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a_src;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? ~cin : cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[int'(cnt_q)*DIGIT_W +: DIGIT_W] = dig_sum;
                carry_d = dig_cout;
                a_d     = a_q >> DIGIT_W;
                b_d     = b_q >> DIGIT_W;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    cout_d  = dig_cout;
                    ovf_d   = dig_cout ^ dig_msb_cin;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=16, DIGIT_W=4) with an arithmetic reference model.
module tb_serial_adder;

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        o;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        cin = 1'b0;
    logic        sub = 1'b0;
`ifdef SERIAL_ADDER_ACC_EN
    logic        acc_sel = 1'b0;
`endif
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    int          nchk = 0;
    int          nerr = 0;
    exp_t        expq[$];
    logic [15:0] last_sum = '0;

    always #5 clk = ~clk;

    serial_adder #(
        .WIDTH  (16),
        .DIGIT_W(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .sub      (sub),
`ifdef SERIAL_ADDER_ACC_EN
        .acc_sel  (acc_sel),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .ovf      (ovf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        nchk++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    function automatic exp_t model(input logic [15:0] x, input logic [15:0] y,
                                   input logic c, input logic s);
        exp_t        e;
        logic [16:0] u;
        int          r;
        if (!s) begin
            u   = {1'b0, x} + {1'b0, y} + {16'b0, c};
            r   = int'($signed(x)) + int'($signed(y)) + int'(c);
            e.c = u[16];
        end else begin
            u   = {1'b0, x} - {1'b0, y} - {16'b0, c};
            r   = int'($signed(x)) - int'($signed(y)) - int'(c);
            e.c = ({1'b0, x} >= ({1'b0, y} + {16'b0, c}));
        end
        e.s = u[15:0];
        e.o = (r > 32767) || (r < -32768);
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst === 1'b0 && out_valid === 1'b1) begin
            if (expq.size() == 0) begin
                nchk++;
                nerr++;
                $display("FAIL unexpected_out: got out_valid=1, required 0 (nothing outstanding)");
            end else begin
                chk("model_sum", 32'(sum), 32'(expq[0].s));
                chk("model_cout", 32'(cout), 32'(expq[0].c));
                chk("model_ovf", 32'(ovf), 32'(expq[0].o));
                chk("busy_in_ready", 32'(in_ready), 32'd0);
            end
        end
    end

    always @(posedge clk) begin
        if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1 && expq.size() > 0) begin
            last_sum = expq[0].s;
            void'(expq.pop_front());
        end
    end

    task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tcin,
                         input logic tsub, input logic tacc, input int hold,
                         input logic [15:0] lit_s, input logic lit_c, input logic lit_o);
        int          lat;
        logic [15:0] a_eff;
        a_eff = tacc ? last_sum : ta;
        a = ta;
        b = tb_v;
        cin = tcin;
        sub = tsub;
`ifdef SERIAL_ADDER_ACC_EN
        acc_sel = tacc;
`endif
        in_valid = 1'b1;
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        expq.push_back(model(a_eff, tb_v, tcin, tsub));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 16'hDEAD;
        b = 16'hBEEF;
        cin = ~tcin;
        sub = ~tsub;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", 32'(lat), 32'd4);
        chk("lit_sum", 32'(sum), 32'(lit_s));
        chk("lit_cout", 32'(cout), 32'(lit_c));
        chk("lit_ovf", 32'(ovf), 32'(lit_o));
        for (int i = 0; i < hold; i++) begin
            if (i == 1) begin
                a = 16'hAAAA;
                b = 16'h5555;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("release_valid", 32'(out_valid), 32'd0);
        chk("release_in_ready", 32'(in_ready), 32'd1);
        chk("queue_drained", 32'(expq.size()), 32'd0);
    endtask

    initial begin
        #3;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0, 0, 16'h5555, 1'b0, 1'b0);
        do_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0, 0, 16'h0000, 1'b1, 1'b0);
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 0, 16'h8000, 1'b0, 1'b1);
        do_op(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0, 0, 16'hFFFE, 1'b0, 1'b0);
        do_op(16'h0010, 16'h0003, 1'b1, 1'b1, 1'b0, 0, 16'h000C, 1'b1, 1'b0);
        do_op(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0, 0, 16'h7FFF, 1'b1, 1'b1);
        do_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 1'b0, 5, 16'h1000, 1'b0, 1'b0);
        repeat (6) @(posedge clk);
        #1;

        // Abort an operation two digits in, then check the async reset.
        a = 16'h1111;
        b = 16'h2222;
        cin = 1'b0;
        sub = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrun_out_valid", 32'(out_valid), 32'd0);
        chk("midrun_sum", 32'(sum), 32'd0);
        chk("midrun_in_ready", 32'(in_ready), 32'd1);
        expq.delete();
        last_sum = '0;
        #3;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("after_abort_idle", 32'(out_valid), 32'd0);
        do_op(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, 0, 16'h0002, 1'b0, 1'b0);
`ifdef SERIAL_ADDER_ACC_EN
        do_op(16'h9999, 16'h0005, 1'b0, 1'b0, 1'b1, 0, 16'h0007, 1'b0, 1'b0);
`endif
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
